// File: rtl/keypad_event_queue_pkg.sv
// Shared types and constants for the keypad event queue.
package keypad_pkg;

   localparam int unsigned KEY_NUM       = 16;
   localparam int unsigned KEY_IDX_W     = 4;
   localparam int unsigned EVT_PRESS_BIT = 4;
   localparam int unsigned EVT_W         = 5;

   // Event FSM states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } evt_state_e;

   // Queued key event: press flag above the key index
   typedef struct packed {
      logic                 press;
      logic [KEY_IDX_W-1:0] idx;
   } key_evt_t;

endpackage

// File: rtl/keypad_event_queue_if.sv
// GPIO register-window side of the keypad event queue.
interface keypad_event_queue_if #(
   parameter int unsigned FIFO_DEPTH = 8
);
   import keypad_pkg::*;

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic                 pop;
   logic                 clr_ovf;
   logic                 irq_en;
   logic [KEY_NUM-1:0]   key_state;
   logic [EVT_W-1:0]     evt_code;
   logic                 empty;
   logic                 full;
   logic [PTR_W:0]       count;
   logic                 overflow;
   logic                 irq;

   modport master (
      output pop, clr_ovf, irq_en,
      input  key_state, evt_code, empty, full, count, overflow, irq
   );

   modport slave (
      input  pop, clr_ovf, irq_en,
      output key_state, evt_code, empty, full, count, overflow, irq
   );

endinterface

// File: rtl/keypad_evt_fifo.sv
// Generic synchronous FIFO with show-ahead head, occupancy count and flags.
module keypad_evt_fifo #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign empty = (count == '0);
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign rdata = empty ? '0 : mem[rd_ptr];

   // Storage array, written only on accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_event_queue.sv
// Debounces the keypad vector and queues press/release events for the CPU.
module keypad_event_queue
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20000,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_NUM-1:0]  keypad,
   keypad_event_queue_if.slave bus
);
   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [KEY_NUM-1:0]   sync_1;
   logic [KEY_NUM-1:0]   ks;
   logic [KEY_NUM-1:0]   cand;
   logic [CNT_W-1:0]     cnt;
   logic [KEY_NUM-1:0]   key_state;
   logic [KEY_NUM-1:0]   diff;
   logic [KEY_NUM-1:0]   new_keys;
   evt_state_e           state;
   logic [KEY_IDX_W-1:0] pick_idx;
   logic [KEY_NUM-1:0]   pick_oh;
   logic                 commit_c;
   logic                 push_c;
   key_evt_t             push_evt;
   logic [EVT_W-1:0]     fifo_head;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [PTR_W:0]       fifo_count;
   logic                 overflow;
   logic                 irq;

   // Two-flop synchroniser for the asynchronous scanner vector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1 <= '0;
         ks     <= '0;
      end else begin
         sync_1 <= keypad;
         ks     <= sync_1;
      end
   end

   // Debounce: restart on any change, saturate once the candidate is stable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand <= '0;
         cnt  <= '0;
      end else if (ks != cand) begin
         cand <= ks;
         cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign commit_c = (cnt == CNT_MAX) && (cand != key_state) && (state == ST_IDLE);

   // Lowest set bit of the pending change mask
   always_comb begin
      pick_idx = '0;
      for (int i = KEY_NUM - 1; i >= 0; i--) begin
         if (diff[i]) pick_idx = KEY_IDX_W'(i);
      end
      pick_oh = KEY_NUM'(1) << pick_idx;
   end

   assign push_c         = (state == ST_EMIT);
   assign push_evt.press = new_keys[pick_idx];
   assign push_evt.idx   = pick_idx;

   // Event FSM: commit the debounced vector, then emit one event per changed key
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         key_state <= '0;
         diff      <= '0;
         new_keys  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (commit_c) begin
                  key_state <= cand;
                  diff      <= cand ^ key_state;
                  new_keys  <= cand;
                  state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               diff <= diff & ~pick_oh;
               if ((diff & ~pick_oh) == '0) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   keypad_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .wdata (push_evt),
      .pop   (bus.pop),
      .rdata (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // Sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (push_c && fifo_full && !bus.pop) begin
         overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   // Level interrupt while events are pending
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) irq <= 1'b0;
      else      irq <= bus.irq_en & ~fifo_empty;
   end

   assign bus.key_state = key_state;
   assign bus.evt_code  = fifo_head;
   assign bus.empty     = fifo_empty;
   assign bus.full      = fifo_full;
   assign bus.count     = fifo_count;
   assign bus.overflow  = overflow;
   assign bus.irq       = irq;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Randomised bench for keypad_event_queue against a queue-based reference model.
module tb_keypad_event_queue;

   localparam int unsigned DB    = 4;
   localparam int unsigned DEPTH = 4;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic [15:0] keypad = '0;

   keypad_event_queue_if #(.FIFO_DEPTH(DEPTH)) bus();

   keypad_event_queue #(
      .DEBOUNCE_CYCLES (DB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .keypad (keypad),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [15:0] hist[$];   // hist[j] = keypad sampled j edges ago
   logic [4:0]  sched[$];  // events still to be emitted, one per edge
   logic [4:0]  fq[$];     // FIFO contents, head first
   logic [15:0] m_ks;
   logic        m_ovf;
   logic        m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist = {};
      for (int j = 0; j < int'(DB) + 3; j++) hist.push_back(16'h0);
      sched = {};
      fq    = {};
      m_ks  = '0;
      m_ovf = 1'b0;
      m_irq = 1'b0;
   endtask

   // One clock edge of the specified behaviour
   task automatic model_edge();
      logic [4:0]  pe;
      bit          has_push;
      bit          stable;
      bit          do_pop;
      bit          set_ovf;
      int          sz0;
      logic [15:0] w;
      pe       = '0;
      has_push = (sched.size() > 0);
      if (has_push) pe = sched.pop_front();
      // Input must have been stable DB samples, seen through a 3-edge path
      hist.push_front(keypad);
      hist.delete(int'(DB) + 3);
      w      = hist[3];
      stable = 1'b1;
      for (int j = 3; j < int'(DB) + 3; j++) if (hist[j] != w) stable = 1'b0;
      if (!has_push && stable && (w != m_ks)) begin
         for (int b = 0; b < 16; b++)
            if (w[b] != m_ks[b]) sched.push_back({w[b], 4'(b)});
         m_ks = w;
      end
      sz0     = fq.size();
      m_irq   = bus.irq_en && (sz0 > 0);
      do_pop  = bus.pop && (sz0 > 0);
      set_ovf = 1'b0;
      if (do_pop) void'(fq.pop_front());
      if (has_push) begin
         if (sz0 < int'(DEPTH) || do_pop) fq.push_back(pe);
         else set_ovf = 1'b1;
      end
      if (set_ovf)          m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
   endtask

   task automatic compare_outputs();
      logic [4:0] head;
      head = (fq.size() > 0) ? fq[0] : 5'h00;
      check("key_state", 32'(bus.key_state), 32'(m_ks));
      check("evt_code",  32'(bus.evt_code),  32'(head));
      check("empty",     32'(bus.empty),     32'(fq.size() == 0));
      check("full",      32'(bus.full),      32'(fq.size() == int'(DEPTH)));
      check("count",     32'(bus.count),     32'(fq.size()));
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
      check("irq",       32'(bus.irq),       32'(m_irq));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      else     model_reset();
      #1;
      compare_outputs();
   endtask

   task automatic drain();
      bus.pop = 1'b1;
      repeat (DEPTH + 1) step();
      bus.pop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [4:0] multi_exp [4];
      multi_exp[0] = 5'h00; multi_exp[1] = 5'h01;
      multi_exp[2] = 5'h12; multi_exp[3] = 5'h18;

      bus.pop     = 1'b0;
      bus.clr_ovf = 1'b0;
      bus.irq_en  = 1'b1;
      model_reset();
      #1 rst = 1'b0;
      #1 compare_outputs();
      repeat (2) step();
      rst = 1'b1;
      repeat (3) step();

      // Single press then release
      keypad = 16'h0020;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (lat == 0 && bus.key_state == 16'h0020) lat = i + 1;
      end
      check("press_latency", 32'(lat), 32'(DB + 3));
      check("press_head", 32'(bus.evt_code), 32'h15);
      keypad = 16'h0000;
      repeat (20) step();
      check("release_count", 32'(bus.count), 32'd2);
      drain();

      // Short glitch must not commit
      keypad = 16'h0001;
      repeat (3) step();
      keypad = 16'h0000;
      repeat (15) step();
      check("glitch_empty", 32'(bus.empty), 32'd1);
      check("glitch_state", 32'(bus.key_state), 32'h0);

      // Multi-bit change emitted in ascending index order
      keypad = 16'h0003;
      repeat (15) step();
      drain();
      keypad = 16'h0104;
      repeat (15) step();
      check("multi_count", 32'(bus.count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("multi_order", 32'(bus.evt_code), 32'(multi_exp[i]));
         bus.pop = 1'b1;
         step();
         bus.pop = 1'b0;
      end

      // Six events with no pops: first four kept, overflow set
      keypad = 16'h003F;
      repeat (15) step();
      check("ovf_count", 32'(bus.count), 32'd4);
      check("ovf_full", 32'(bus.full), 32'd1);
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      check("ovf_head", 32'(bus.evt_code), 32'h10);
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      check("ovf_clear", 32'(bus.overflow), 32'd0);

      // Push into a full FIFO with a pop in the same cycle
      keypad = 16'h007F;
      repeat (DB + 3) step();
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      check("fullpop_count", 32'(bus.count), 32'd4);
      check("fullpop_ovf", 32'(bus.overflow), 32'd0);
      check("fullpop_head", 32'(bus.evt_code), 32'h11);
      drain();

      // Reset during a three-event burst
      keypad = 16'h0078;
      repeat (DB + 4) step();
      #2 rst = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      check("rst_empty", 32'(bus.empty), 32'd1);
      repeat (2) step();
      rst = 1'b1;
      repeat (20) step();
      check("rst_state", 32'(bus.key_state), 32'h0078);
      check("rst_count", 32'(bus.count), 32'd4);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      drain();

      // Random key activity, glitches, pops, clears and irq enables
      begin
         int hold;
         hold = 0;
         for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
               logic [15:0] flip;
               flip = 16'(1) << $urandom_range(0, 15);
               if ($urandom_range(0, 2) == 0) flip = flip | (16'(1) << $urandom_range(0, 15));
               keypad = keypad ^ flip;
               hold   = int'($urandom_range(1, 10));
            end
            hold--;
            bus.pop     = ($urandom_range(0, 3) == 0);
            bus.clr_ovf = ($urandom_range(0, 15) == 0);
            bus.irq_en  = ($urandom_range(0, 7) != 0);
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
